// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: byte width and the
// transmit sequencer state encoding.
package uart_pkg;

   localparam int UART_DW = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      GAP  = 2'd2
   } state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous byte FIFO with registered full/empty flags and an occupancy
// count. Writes while full and reads while empty are ignored.
module uart_sync_fifo
   import uart_pkg::*;
#(
   parameter  int DEPTH = 16,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [UART_DW-1:0] i_wr_data,
   input  logic               i_wr_en,
   input  logic               i_rd_en,
   output logic [UART_DW-1:0] o_rd_data,
   output logic               o_full,
   output logic               o_empty,
   output logic [AW:0]        o_level
);

   logic [UART_DW-1:0] r_mem [DEPTH];
   logic [AW-1:0]      r_wr_ptr;
   logic [AW-1:0]      r_rd_ptr;
   logic [AW:0]        r_level;
   logic               r_full;
   logic               r_empty;
   logic               w_wr_acc;
   logic               w_rd_acc;
   logic [AW:0]        w_level_next;

   assign w_wr_acc = i_wr_en & ~r_full;
   assign w_rd_acc = i_rd_en & ~r_empty;

   always_comb begin
      w_level_next = r_level;
      case ({w_wr_acc, w_rd_acc})
         2'b10:   w_level_next = r_level + (AW+1)'(1);
         2'b01:   w_level_next = r_level - (AW+1)'(1);
         default: w_level_next = r_level;
      endcase
   end

   // Storage carries no reset; stale entries are never visible past rd_ptr.
   always_ff @(posedge clk) begin
      if (w_wr_acc) begin
         r_mem[r_wr_ptr] <= i_wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
         r_full   <= 1'b0;
         r_empty  <= 1'b1;
      end else begin
         if (w_wr_acc) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_rd_acc) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         r_level <= w_level_next;
         r_full  <= (w_level_next == (AW+1)'(DEPTH));
         r_empty <= (w_level_next == '0);
      end
   end

   assign o_rd_data = r_mem[r_rd_ptr];
   assign o_full    = r_full;
   assign o_empty   = r_empty;
   assign o_level   = r_level;

endmodule

// File: rtl/uart_tx_feeder.sv
// Buffered byte feeder for the UART serial sender: holds one byte on tx_data
// with tx_enable high until tx_done. Optional sticky overflow flag is built
// when UART_TX_FEEDER_OVF_EN is defined.
module uart_tx_feeder
   import uart_pkg::*;
#(
   parameter  int DEPTH = 16,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [UART_DW-1:0] wr_data,
   input  logic               wr_en,
   output logic               full,
   output logic               empty,
   output logic [AW:0]        level,
   output logic [UART_DW-1:0] tx_data,
   output logic               tx_enable,
   input  logic               tx_done,
   output logic               busy,
   output logic               ovf,
   input  logic               ovf_clr
);

   state_t             r_state;
   logic [UART_DW-1:0] r_tx_data;
   logic               r_tx_enable;
   logic               r_busy;
   logic               w_rd_acc;
   logic [UART_DW-1:0] w_fifo_data;

   assign w_rd_acc = (r_state == IDLE) & ~empty;

   uart_sync_fifo #(
      .DEPTH(DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_wr_data (wr_data),
      .i_wr_en   (wr_en),
      .i_rd_en   (w_rd_acc),
      .o_rd_data (w_fifo_data),
      .o_full    (full),
      .o_empty   (empty),
      .o_level   (level)
   );

   // GAP keeps tx_enable low for the cycle in which the sender returns to
   // idle, so it cannot restart on the byte it has just finished.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_tx_data   <= '0;
         r_tx_enable <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_rd_acc) begin
                  r_tx_data   <= w_fifo_data;
                  r_tx_enable <= 1'b1;
                  r_busy      <= 1'b1;
                  r_state     <= SEND;
               end
            end
            SEND: begin
               if (tx_done) begin
                  r_tx_enable <= 1'b0;
                  r_state     <= GAP;
               end
            end
            GAP: begin
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
            default: begin
               r_tx_enable <= 1'b0;
               r_busy      <= 1'b0;
               r_state     <= IDLE;
            end
         endcase
      end
   end

   assign tx_data   = r_tx_data;
   assign tx_enable = r_tx_enable;
   assign busy      = r_busy;

`ifdef UART_TX_FEEDER_OVF_EN
   logic r_ovf;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ovf <= 1'b0;
      end else if (wr_en & full) begin
         r_ovf <= 1'b1;
      end else if (ovf_clr) begin
         r_ovf <= 1'b0;
      end
   end

   assign ovf = r_ovf;
`else
   logic w_unused_ovf_clr;

   assign w_unused_ovf_clr = ovf_clr;
   assign ovf              = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Self-checking bench for uart_tx_feeder: a queue-based reference model is
// compared every cycle, plus directed checks with literal expectations.
module tb_uart_tx_feeder;

   localparam int DEPTH = 16;
   localparam int AW    = $clog2(DEPTH);

`ifdef UART_TX_FEEDER_OVF_EN
   localparam logic OVF_EN = 1'b1;
`else
   localparam logic OVF_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  wr_data;
   logic        wr_en;
   logic        full;
   logic        empty;
   logic [AW:0] level;
   logic [7:0]  tx_data;
   logic        tx_enable;
   logic        tx_done;
   logic        busy;
   logic        ovf;
   logic        ovf_clr;

   int checks = 0;
   int errors = 0;
   bit modelReady = 1'b0;

   always #5 clk = ~clk;

   uart_tx_feeder #(
      .DEPTH(DEPTH)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_data   (wr_data),
      .wr_en     (wr_en),
      .full      (full),
      .empty     (empty),
      .level     (level),
      .tx_data   (tx_data),
      .tx_enable (tx_enable),
      .tx_done   (tx_done),
      .busy      (busy),
      .ovf       (ovf),
      .ovf_clr   (ovf_clr)
   );

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a byte queue plus the presented byte and handshake flags.
   logic [7:0] mQ[$];
   logic [7:0] mTxData;
   logic       mTxEn;
   logic       mBusy;
   logic       mOvf;
   logic       mWasFull;
   logic       mCanPop;
   logic [7:0] mHead;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mQ.delete();
         mTxData = 8'h00;
         mTxEn   = 1'b0;
         mBusy   = 1'b0;
         mOvf    = 1'b0;
      end else begin
         mWasFull = (mQ.size() == DEPTH);
         mCanPop  = !mBusy && (mQ.size() > 0);
         mHead    = 8'h00;
         if (mCanPop) mHead = mQ.pop_front();
         if (wr_en && !mWasFull) mQ.push_back(wr_data);
         if (mCanPop) begin
            mTxData = mHead;
            mTxEn   = 1'b1;
            mBusy   = 1'b1;
         end else if (mTxEn && tx_done) begin
            mTxEn = 1'b0;
         end else if (mBusy && !mTxEn) begin
            mBusy = 1'b0;
         end
         if (OVF_EN) begin
            if (wr_en && mWasFull) mOvf = 1'b1;
            else if (ovf_clr)      mOvf = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      if (modelReady) begin
         checkOutput("txEnable", tx_enable, mTxEn);
         checkOutput("txData",   tx_data,   mTxData);
         checkOutput("busy",     busy,      mBusy);
         checkOutput("level",    level,     mQ.size());
         checkOutput("full",     full,      (mQ.size() == DEPTH));
         checkOutput("empty",    empty,     (mQ.size() == 0));
         checkOutput("ovf",      ovf,       mOvf);
      end
   end

   task automatic applyStimulus(input logic wr, input logic [7:0] d, input logic done, input logic clr);
      wr_en   = wr;
      wr_data = d;
      tx_done = done;
      ovf_clr = clr;
      @(posedge clk);
      #2;
      wr_en   = 1'b0;
      tx_done = 1'b0;
      ovf_clr = 1'b0;
   endtask

   // Plays the sender: waits for tx_enable, holds for 'hold' edges, pulses tx_done.
   task automatic serveFrame(input int hold, output logic [7:0] b, output int waited);
      waited = 0;
      b      = 8'h00;
      while (tx_enable !== 1'b1 && waited < 300) begin
         applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
         waited++;
      end
      if (tx_enable !== 1'b1) begin
         checkOutput("frameStartTimeout", tx_enable, 1);
         return;
      end
      b = tx_data;
      repeat (hold - 1) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
   endtask

   logic [7:0] b;
   int         w;

   initial begin
      rst_n   = 1'b0;
      wr_en   = 1'b0;
      wr_data = 8'h00;
      tx_done = 1'b0;
      ovf_clr = 1'b0;

      // Test 1: reset values
      #12;
      modelReady = 1'b1;
      checkOutput("rstTxEnable", tx_enable, 0);
      checkOutput("rstTxData",   tx_data,   8'h00);
      checkOutput("rstEmpty",    empty,     1);
      checkOutput("rstFull",     full,      0);
      checkOutput("rstLevel",    level,     0);
      checkOutput("rstBusy",     busy,      0);
      checkOutput("rstOvf",      ovf,       0);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);

      // Test 2: single byte
      $display("[TB] single byte");
      applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0);
      checkOutput("t2EmptyAfterWrite", empty, 0);
      checkOutput("t2EnableNotYet", tx_enable, 0);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      checkOutput("t2EnableHigh", tx_enable, 1);
      checkOutput("t2Data", tx_data, 8'hA5);
      repeat (5) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      checkOutput("t2StillHeld", tx_data, 8'hA5);
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      checkOutput("t2EnableLow", tx_enable, 0);
      checkOutput("t2BusyGap", busy, 1);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      checkOutput("t2BusyIdle", busy, 0);
      checkOutput("t2Level", level, 0);
      checkOutput("t2DataKept", tx_data, 8'hA5);

      // Test 3: burst of three, 100-cycle frames
      $display("[TB] burst");
      applyStimulus(1'b1, 8'h11, 1'b0, 1'b0);
      applyStimulus(1'b1, 8'h22, 1'b0, 1'b0);
      applyStimulus(1'b1, 8'h33, 1'b0, 1'b0);
      serveFrame(100, b, w);
      checkOutput("t3Byte0", b, 8'h11);
      serveFrame(100, b, w);
      checkOutput("t3Byte1", b, 8'h22);
      checkOutput("t3Gap1", w, 2);
      serveFrame(100, b, w);
      checkOutput("t3Byte2", b, 8'h33);
      checkOutput("t3Gap2", w, 2);
      repeat (2) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);

      // Test 4: overflow; 0x00 is popped, 0x01..0x10 fill, 0x11 is dropped
      $display("[TB] overflow");
      for (int i = 0; i < 18; i++) applyStimulus(1'b1, 8'(i), 1'b0, 1'b0);
      checkOutput("t4Full", full, 1);
      checkOutput("t4Level", level, 16);
      checkOutput("t4Ovf", ovf, OVF_EN);
      applyStimulus(1'b1, 8'h55, 1'b0, 1'b1);
      checkOutput("t4OvfSetWins", ovf, OVF_EN);
      checkOutput("t4LevelHeld", level, 16);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
      checkOutput("t4OvfCleared", ovf, 0);
      for (int i = 0; i < 17; i++) begin
         serveFrame(3, b, w);
         checkOutput($sformatf("t4Drain%0d", i), b, i);
         if (i > 0) checkOutput($sformatf("t4DrainGap%0d", i), w, 2);
      end
      repeat (6) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      checkOutput("t4NoExtraFrame", tx_enable, 0);
      checkOutput("t4DrainedEmpty", empty, 1);
      checkOutput("t4LastByte", tx_data, 8'h10);

      // Test 5: write and pop on the same edge with level=1
      $display("[TB] simultaneous write and pop");
      applyStimulus(1'b1, 8'h61, 1'b0, 1'b0);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      checkOutput("t5FirstData", tx_data, 8'h61);
      applyStimulus(1'b1, 8'h62, 1'b0, 1'b0);
      repeat (3) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      checkOutput("t5LevelBefore", level, 1);
      checkOutput("t5BusyIdle", busy, 0);
      applyStimulus(1'b1, 8'h63, 1'b0, 1'b0);
      checkOutput("t5LevelSame", level, 1);
      checkOutput("t5Enable", tx_enable, 1);
      checkOutput("t5Data", tx_data, 8'h62);
      serveFrame(3, b, w);
      checkOutput("t5ByteA", b, 8'h62);
      serveFrame(3, b, w);
      checkOutput("t5ByteB", b, 8'h63);
      checkOutput("t5Gap", w, 2);
      repeat (2) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);

      // Test 6: reset during SEND with three bytes queued
      $display("[TB] reset mid-frame");
      applyStimulus(1'b1, 8'h71, 1'b0, 1'b0);
      applyStimulus(1'b1, 8'h72, 1'b0, 1'b0);
      applyStimulus(1'b1, 8'h73, 1'b0, 1'b0);
      applyStimulus(1'b1, 8'h74, 1'b0, 1'b0);
      checkOutput("t6Level", level, 3);
      checkOutput("t6Sending", tx_enable, 1);
      checkOutput("t6SendData", tx_data, 8'h71);
      #1;
      rst_n = 1'b0;
      #1;
      checkOutput("t6AsyncEnable", tx_enable, 0);
      checkOutput("t6AsyncEmpty", empty, 1);
      checkOutput("t6AsyncLevel", level, 0);
      checkOutput("t6AsyncBusy", busy, 0);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      repeat (10) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      checkOutput("t6NoSend", tx_enable, 0);
      checkOutput("t6Empty", empty, 1);
      checkOutput("t6Busy", busy, 0);
      checkOutput("t6Data", tx_data, 8'h00);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
